// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared constants and state type for the BRAM stream reader.
package bram_stream_reader_pkg;
    localparam int DW_DEF        = 16;
    localparam int RD_FIFO_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, RUN, FIN} rd_state_t;
endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: valid/ready output stream carrying data words with a last flag.
interface bram_stream_reader_if #(
    parameter int DW = 16
);
    logic          valid;
    logic          ready;
    logic          last;
    logic [DW-1:0] data;
    modport master(output valid, data, last, input ready);
    modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/bram_stream_reader_fifo.sv
// bram_stream_reader_fifo: small register FIFO holding read data between BRAM and consumer.
module bram_stream_reader_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          din,
    input  logic                   pop,
    output logic [DW-1:0]          dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr;
    logic [PW-1:0] rd;
    logic          do_pop;

    assign do_pop = pop && valid;
    assign valid  = count != '0;
    assign dout   = mem[rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= wr + PW'(1);
            end
            if (do_pop) rd <= rd + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: issues sequential BRAM reads and presents the words as a valid/ready stream.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [LW-1:0]        len,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_dout,
    bram_stream_reader_if.master m
);
    localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;
    rd_state_t     state;
    rd_state_t     state_n;
    logic [LW-1:0] len_q;
    logic [LW-1:0] issued;
    logic [LW-1:0] sent;
    logic [AW-1:0] addr;
    logic          inflight;
    logic          hs;
    logic          valid;
    logic [DW-1:0] head;
    logic [CW-1:0] count;

    // Credit check uses the pre-pop occupancy so a read never lands in a full FIFO.
    assign mem_en   = state == RUN && issued < len_q && (count + CW'(inflight)) < CW'(RD_FIFO_DEPTH);
    assign mem_we   = 1'b0;
    assign mem_addr = addr;
    assign busy     = state == RUN;
    assign done     = state == FIN;
    assign hs       = valid && m.ready;
    assign m.valid  = valid;
    assign m.data   = head;
    assign m.last   = valid && sent == len_q - LW'(1);

    bram_stream_reader_fifo #(.DW(DW), .DEPTH(RD_FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (mem_dout),
        .pop   (m.ready),
        .dout  (head),
        .valid (valid),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (len != '0) ? RUN : FIN;
            RUN:     if (hs && m.last) state_n = FIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            issued   <= '0;
            sent     <= '0;
            addr     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_en;
            if (state == IDLE && start) begin
                len_q  <= len;
                issued <= '0;
                sent   <= '0;
                addr   <= base_addr;
            end else begin
                if (mem_en) begin
                    issued <= issued + LW'(1);
                    addr   <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
                end
                if (hs) sent <= sent + LW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: randomized scoreboard bench for bram_stream_reader with a behavioural BRAM.
module tb_bram_stream_reader;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int LW    = 11;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] bram [DEPTH];

    bram_stream_reader_if #(.DW(DW)) m();

    bram_stream_reader #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .m         (m)
    );

    int    errors = 0;
    int    checks = 0;
    int    done_cnt = 0;
    int    en_cnt = 0;
    int    hs_cnt = 0;
    int    en0 = 0;
    bit    rand_ready = 1'b0;
    beat_t exp_q[$];
    int    addr_q[$];

    always #5 clk = ~clk;

    initial for (int i = 0; i < DEPTH; i++) bram[i] = DW'(i * 3);

    always @(posedge clk) if (mem_en) mem_dout <= bram[mem_addr];

    initial begin
        m.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every presented beat and every read strobe against the model queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (mem_en) begin
                check("mem_we", mem_we, 0);
                check("credit_limit", (en_cnt - hs_cnt) < 4, 1);
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_en: got addr %0d required no read", mem_addr);
                end else check("mem_addr", mem_addr, addr_q.pop_front());
                en_cnt++;
            end
            if (m.valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0d required no beat", m.data);
                end else begin
                    check("m_data", m.data, exp_q[0].data);
                    check("m_last", m.last, exp_q[0].last);
                    if (m.ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    task automatic check_zero_outputs(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_m_valid"}, m.valid, 0);
        check({tag, "_m_last"}, m.last, 0);
        check({tag, "_m_data"}, m.data, 0);
    endtask

    task automatic start_xfer(int b, int l);
        @(posedge clk);
        #1;
        done_cnt  = 0;
        en0       = en_cnt;
        base_addr = AW'(b);
        len       = LW'(l);
        start     = 1'b1;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back('{data: DW'(((b + i) % DEPTH) * 3), last: (i == l - 1)});
            addr_q.push_back((b + i) % DEPTH);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_xfer(int l, int exp_first, int exp_done);
        int n = 1;
        int first_v = 0;
        while (!done && n < 300) begin
            if (m.valid && first_v == 0) first_v = n;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles required 1", n);
        end else begin
            check("busy_at_done", busy, 0);
            if (exp_done >= 0) check("done_cycle", n, exp_done);
        end
        if (exp_first >= 0) check("first_valid_cycle", first_v, exp_first);
        @(posedge clk);
        #1;
        check("done_width", done, 0);
        check("done_count", done_cnt, 1);
        check("beats_left", exp_q.size(), 0);
        check("mem_en_count", en_cnt - en0, l);
    endtask

    initial begin
        int hs0;
        int n;
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int hs0;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        start_xfer(10, 5);
        finish_xfer(5, 3, 8);

        start_xfer(1020, 6);
        finish_xfer(6, 3, 9);

        start_xfer(5, 0);
        finish_xfer(0, -1, 1);

        start_xfer(0, 4);
        @(posedge clk);
        #1;
        base_addr = AW'(100);
        len       = LW'(7);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_xfer(4, -1, -1);

        rand_ready = 1'b1;
        start_xfer(int'($urandom_range(0, DEPTH - 1)), 8);
        finish_xfer(8, -1, -1);
        for (int t = 0; t < 4; t++) begin
            int l = int'($urandom_range(1, 16));
            start_xfer(int'($urandom_range(0, DEPTH - 1)), l);
            finish_xfer(l, -1, -1);
        end
        rand_ready = 1'b0;

        start_xfer(0, 10);
        hs0 = hs_cnt;
        n = 0;
        while (hs_cnt - hs0 < 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("two_beats_before_reset", hs_cnt - hs0 >= 2, 1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        exp_q.delete();
        addr_q.delete();
        en_cnt = 0;
        hs_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_xfer(0, 3);
        finish_xfer(3, 3, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
